// File: rtl/knight_pkg.sv
// Shared types and constants for the command deserializer: FSM encodings, the
// default inter-byte timeout and the two acknowledge codes sent back to the host.
package knight_pkg;

    localparam int         GAP_CYCLES_DEF = 1_000_000;
    localparam logic [7:0] POS_ACK        = 8'hA5;
    localparam logic [7:0] MOVE_ACK       = 8'h5A;

    typedef enum logic {
        RX_HIGH = 1'b0,
        RX_LOW  = 1'b1
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

endpackage

// File: rtl/resp_queue.sv
// Response transmitter: one byte in flight plus a one-deep pending slot; trmt one clock after accept.
// Requests arriving while the pending slot is full are dropped; tx_done frees the line.
module resp_queue
    import knight_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] resp,
    input  logic       send_resp,
    input  logic       tx_done,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       resp_sent
);

    tx_state_t  tx_state;
    logic       pend_vld;
    logic [7:0] pend_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            pend_vld  <= 1'b0;
            pend_data <= 8'h00;
            tx_data   <= 8'h00;
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
        end else begin
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
            unique case (tx_state)
                TX_IDLE: begin
                    if (send_resp) begin
                        tx_data  <= resp;
                        trmt     <= 1'b1;
                        tx_state <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (tx_done) begin
                        resp_sent <= 1'b1;
                        if (pend_vld) begin
                            tx_data  <= pend_data;
                            trmt     <= 1'b1;
                            pend_vld <= 1'b0;
                        end else if (send_resp) begin
                            // Request racing the completion goes straight to the line.
                            tx_data  <= resp;
                            trmt     <= 1'b1;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else if (send_resp && !pend_vld) begin
                        pend_data <= resp;
                        pend_vld  <= 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cmd_deserializer.sv
// Assembles 16-bit commands from two UART bytes (cmd_rdy one clock after low byte) and returns responses.
// Receiver bytes are consumed the cycle they appear; a stalled low byte times out with gap_err.
module cmd_deserializer
    import knight_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        gap_err
);

    localparam int            CW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    rx_state_t     rx_state;
    logic [7:0]    high_byte;
    logic [CW-1:0] gap_cnt;

    assign clr_rx_rdy = rx_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state  <= RX_HIGH;
            high_byte <= 8'h00;
            gap_cnt   <= '0;
            cmd       <= 16'h0000;
            cmd_rdy   <= 1'b0;
            gap_err   <= 1'b0;
        end else begin
            gap_err <= 1'b0;
            if (clr_cmd_rdy)
                cmd_rdy <= 1'b0;
            unique case (rx_state)
                RX_HIGH: begin
                    if (rx_rdy) begin
                        high_byte <= rx_data;
                        cmd_rdy   <= 1'b0;
                        gap_cnt   <= '0;
                        rx_state  <= RX_LOW;
                    end
                end
                RX_LOW: begin
                    // A byte arriving on the final count still completes the command.
                    if (rx_rdy) begin
                        cmd      <= {high_byte, rx_data};
                        cmd_rdy  <= 1'b1;
                        rx_state <= RX_HIGH;
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_err  <= 1'b1;
                        gap_cnt  <= '0;
                        rx_state <= RX_HIGH;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_HIGH;
            endcase
        end
    end

    resp_queue u_resp_queue (
        .clk       (clk),
        .rst       (rst),
        .resp      (resp),
        .send_resp (send_resp),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .resp_sent (resp_sent)
    );

endmodule

// File: tb/tb_cmd_deserializer.sv
// Directed bench for cmd_deserializer: table of two-byte commands plus hand-written
// sequences for timeout, acknowledge races, reset mid-command and the response queue.
module tb_cmd_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        resp_sent;
    logic        gap_err;

    int checks   = 0;
    int failures = 0;

    int clr_cnt  = 0;
    int gap_cnt  = 0;
    int sent_cnt = 0;
    logic [7:0] tx_log[$];

    cmd_deserializer #(.GAP_CYCLES(100)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .resp_sent   (resp_sent),
        .gap_err     (gap_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clr_rx_rdy) clr_cnt++;
        if (gap_err)    gap_cnt++;
        if (resp_sent)  sent_cnt++;
        if (trmt)       tx_log.push_back(tx_data);
    end

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        int          gap;
        logic [15:0] exp_cmd;
    } rx_vec_t;

    rx_vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        tick();
        rx_rdy  = 1'b0;
    endtask

    task automatic pulse_resp(input logic [7:0] b);
        resp      = b;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
    endtask

    task automatic pulse_done;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        int clr0, gap0, sent0, log0;
        logic [15:0] prev;

        vecs[0] = '{hi: 8'h20, lo: 8'h35, gap: 9,  exp_cmd: 16'h2035};
        vecs[1] = '{hi: 8'hFF, lo: 8'h00, gap: 0,  exp_cmd: 16'hFF00};
        vecs[2] = '{hi: 8'h5A, lo: 8'hA5, gap: 99, exp_cmd: 16'h5AA5};
        vecs[3] = '{hi: 8'h01, lo: 8'hFE, gap: 3,  exp_cmd: 16'h01FE};

        rst = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
        resp = 8'h00; send_resp = 1'b0; tx_done = 1'b0;
        #1;
        check("reset_cmd",     32'(cmd),        32'h0);
        check("reset_cmd_rdy", 32'(cmd_rdy),    32'h0);
        check("reset_trmt",    32'(trmt),       32'h0);
        check("reset_tx_data", 32'(tx_data),    32'h0);
        check("reset_gap_err", 32'(gap_err),    32'h0);
        check("reset_sent",    32'(resp_sent),  32'h0);
        check("reset_clr_rx",  32'(clr_rx_rdy), 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Table of commands: high byte, idle gap, low byte.
        prev = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            clr0 = clr_cnt; gap0 = gap_cnt;
            send_byte(vecs[i].hi);
            check("hi_clears_rdy", 32'(cmd_rdy), 32'h0);
            check("hi_cmd_holds",  32'(cmd),     32'(prev));
            repeat (vecs[i].gap) tick();
            send_byte(vecs[i].lo);
            check("vec_cmd",     32'(cmd),            32'(vecs[i].exp_cmd));
            check("vec_cmd_rdy", 32'(cmd_rdy),        32'h1);
            tick();
            check("vec_clr_cnt", 32'(clr_cnt - clr0), 32'd2);
            check("vec_no_gap",  32'(gap_cnt - gap0), 32'd0);
            prev = vecs[i].exp_cmd;
        end

        // Timeout: high byte then 100 idle clocks.
        gap0 = gap_cnt;
        send_byte(8'h40);
        repeat (105) tick();
        check("gap_err_once",    32'(gap_cnt - gap0), 32'd1);
        check("gap_cmd_holds",   32'(cmd),            32'(prev));
        check("gap_cmd_rdy_low", 32'(cmd_rdy),        32'h0);
        send_byte(8'h41);
        tick();
        send_byte(8'h02);
        check("after_gap_cmd", 32'(cmd),     32'h4102);
        check("after_gap_rdy", 32'(cmd_rdy), 32'h1);

        // Acknowledge clears cmd_rdy but not cmd.
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        check("ack_rdy_low", 32'(cmd_rdy), 32'h0);
        check("ack_cmd",     32'(cmd),     32'h4102);

        // Acknowledge coinciding with low-byte completion: set wins.
        send_byte(8'h12);
        clr_cmd_rdy = 1'b1;
        send_byte(8'h34);
        clr_cmd_rdy = 1'b0;
        check("race_cmd", 32'(cmd),     32'h1234);
        check("race_rdy", 32'(cmd_rdy), 32'h1);

        // Reset between high and low byte, with a transmission in flight.
        gap0 = gap_cnt; sent0 = sent_cnt;
        send_byte(8'h77);
        pulse_resp(8'hA5);
        #2;
        rst = 1'b1;
        #1;
        check("rst_cmd",     32'(cmd),       32'h0);
        check("rst_cmd_rdy", 32'(cmd_rdy),   32'h0);
        check("rst_trmt",    32'(trmt),      32'h0);
        check("rst_tx_data", 32'(tx_data),   32'h0);
        tick();
        rst = 1'b0;
        tick();
        pulse_done();
        send_byte(8'h00);
        tick();
        send_byte(8'h01);
        repeat (3) tick();
        check("post_rst_cmd",  32'(cmd),              32'h0001);
        check("post_rst_gap",  32'(gap_cnt - gap0),   32'd0);
        check("post_rst_sent", 32'(sent_cnt - sent0), 32'd0);

        // Response queue: A5 sent, 5A pended, 11 dropped.
        sent0 = sent_cnt; log0 = tx_log.size();
        pulse_resp(8'hA5);
        pulse_resp(8'h5A);
        pulse_resp(8'h11);
        repeat (20) tick();
        check("tx_hold_a5", 32'(tx_data), 32'hA5);
        repeat (27) tick();
        pulse_done();
        repeat (49) tick();
        pulse_done();
        repeat (3) tick();
        check("tx_count",  32'(tx_log.size() - log0), 32'd2);
        check("tx_first",  32'(tx_log[log0]),         32'hA5);
        check("tx_second", 32'(tx_log[log0 + 1]),     32'h5A);
        check("tx_sent",   32'(sent_cnt - sent0),     32'd2);

        // tx_done and send_resp together with empty pending slot.
        sent0 = sent_cnt; log0 = tx_log.size();
        pulse_resp(8'hA5);
        repeat (5) tick();
        resp = 8'h5A; send_resp = 1'b1; tx_done = 1'b1;
        tick();
        send_resp = 1'b0; tx_done = 1'b0;
        repeat (5) tick();
        pulse_done();
        repeat (3) tick();
        check("race_tx_count",  32'(tx_log.size() - log0), 32'd2);
        check("race_tx_second", 32'(tx_log[log0 + 1]),     32'h5A);
        check("race_tx_sent",   32'(sent_cnt - sent0),     32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
